fp_addsub_pipe: RTL

//  Parametrised 3-stage pipelined IEEE-754-style floating-point add/subtract with valid/ready

---
 rtl/fp_addsub_pipe.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_pipe
// Description : Three-stage pipelined floating-point add/subtract.
//               - Valid/ready backpressure; holds up to three operations.
//               - Round-to-nearest-even; denormal inputs are flushed to zero.
//               - Handles NaN, Inf and zero operands.
//               - Per-result flags {invalid, overflow, underflow, inexact}.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe #(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = I_EXP + I_MNT + 1,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sub,
  input  logic [I_DATA-1:0] idataA,
  input  logic [I_DATA-1:0] idataB,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [I_DATA-1:0] odata,
  output logic [TAG_W-1:0]  out_tag,
  output logic [3:0]        out_flags
);

  // Aligned mantissa layout: hidden, stored mantissa, guard, round, sticky
  localparam int c_SW  = I_MNT + 4;
  localparam int c_EW  = I_EXP + 2;
  localparam int c_LZW = $clog2(c_SW) + 1;
  localparam logic [I_EXP-1:0]        c_EXP_ONES = '1;
  localparam logic signed [c_EW-1:0]  c_EXP_INF  = c_EW'((1 << I_EXP) - 1);
  localparam logic [I_DATA-1:0]       c_QNAN     = {1'b0, c_EXP_ONES, 1'b1, {(I_MNT-1){1'b0}}};

  // ---------------------------------------------------------------- handshake
  logic r_v1, r_v2, r_v3;
  logic w_en1, w_en2, w_en3;

  assign w_en3     = ~r_v3 | out_ready;
  assign w_en2     = ~r_v2 | w_en3;
  assign w_en1     = ~r_v1 | w_en2;
  assign in_ready  = w_en1;
  assign out_valid = r_v3;

  // ---------------------------------------------------------------- stage 1
  logic             w_sa, w_sb;
  logic [I_EXP-1:0] w_ea, w_eb;
  logic [I_MNT-1:0] w_ma, w_mb;
  logic             w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_a_big;

  assign w_sa    = idataA[I_DATA-1];
  assign w_sb    = idataB[I_DATA-1] ^ in_sub;
  assign w_ea    = idataA[I_DATA-2:I_MNT];
  assign w_eb    = idataB[I_DATA-2:I_MNT];
  assign w_ma    = idataA[I_MNT-1:0];
  assign w_mb    = idataB[I_MNT-1:0];
  assign w_za    = (w_ea == '0);
  assign w_zb    = (w_eb == '0);
  assign w_ia    = (w_ea == c_EXP_ONES) && (w_ma == '0);
  assign w_ib    = (w_eb == c_EXP_ONES) && (w_mb == '0);
  assign w_na    = (w_ea == c_EXP_ONES) && (w_ma != '0);
  assign w_nb    = (w_eb == c_EXP_ONES) && (w_mb != '0);
  assign w_a_big = (w_ea > w_eb) || ((w_ea == w_eb) && (w_ma >= w_mb));

  logic              w1_spec;
  logic [I_DATA-1:0] w1_spec_data;
  logic [3:0]        w1_spec_flags;

  // Special-operand results that bypass the arithmetic path
  always_comb begin
    w1_spec       = 1'b1;
    w1_spec_data  = '0;
    w1_spec_flags = '0;
    if (w_na || w_nb) begin
      w1_spec_data     = c_QNAN;
      w1_spec_flags[3] = (w_na & ~w_ma[I_MNT-1]) | (w_nb & ~w_mb[I_MNT-1]);
    end else if (w_ia && w_ib) begin
      if (w_sa == w_sb) begin
        w1_spec_data = {w_sa, c_EXP_ONES, {I_MNT{1'b0}}};
      end else begin
        w1_spec_data     = c_QNAN;
        w1_spec_flags[3] = 1'b1;
      end
    end else if (w_ia) begin
      w1_spec_data = {w_sa, c_EXP_ONES, {I_MNT{1'b0}}};
    end else if (w_ib) begin
      w1_spec_data = {w_sb, c_EXP_ONES, {I_MNT{1'b0}}};
    end else if (w_za && w_zb) begin
      w1_spec_data = {w_sa & w_sb, {(I_DATA-1){1'b0}}};
    end else if (w_za) begin
      w1_spec_data = {w_sb, w_eb, w_mb};
    end else if (w_zb) begin
      w1_spec_data = {w_sa, w_ea, w_ma};
    end else begin
      w1_spec = 1'b0;
    end
  end

  logic [TAG_W-1:0]  r1_tag;
  logic              r1_spec, r1_sign, r1_sub;
  logic [I_DATA-1:0] r1_spec_data;
  logic [3:0]        r1_spec_flags;
  logic [I_EXP-1:0]  r1_exp, r1_diff;
  logic [I_MNT:0]    r1_mnt_l, r1_mnt_s;

  // Stage 1 register: operands ordered by magnitude, exponent difference
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1          <= 1'b0;
      r1_tag        <= '0;
      r1_spec       <= 1'b0;
      r1_spec_data  <= '0;
      r1_spec_flags <= '0;
      r1_sign       <= 1'b0;
      r1_sub        <= 1'b0;
      r1_exp        <= '0;
      r1_diff       <= '0;
      r1_mnt_l      <= '0;
      r1_mnt_s      <= '0;
    end else if (w_en1) begin
      r_v1          <= in_valid;
      r1_tag        <= in_tag;
      r1_spec       <= w1_spec;
      r1_spec_data  <= w1_spec_data;
      r1_spec_flags <= w1_spec_flags;
      r1_sign       <= w_a_big ? w_sa : w_sb;
      r1_sub        <= w_sa ^ w_sb;
      r1_exp        <= w_a_big ? w_ea : w_eb;
      r1_diff       <= w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
      r1_mnt_l      <= {1'b1, (w_a_big ? w_ma : w_mb)};
      r1_mnt_s      <= {1'b1, (w_a_big ? w_mb : w_ma)};
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [c_SW-1:0] w2_ext, w2_al;
  logic            w2_sticky;
  logic [c_SW:0]   w2_sum;

  // Align the smaller mantissa with sticky collection, then add or subtract
  always_comb begin
    w2_ext    = {r1_mnt_s, 3'b000};
    w2_sticky = |(w2_ext & ~({c_SW{1'b1}} << r1_diff));
    if (int'(r1_diff) >= c_SW - 1) begin
      w2_al = {{(c_SW-1){1'b0}}, 1'b1};
    end else begin
      w2_al = (w2_ext >> r1_diff) | {{(c_SW-1){1'b0}}, w2_sticky};
    end
    if (r1_sub) begin
      w2_sum = {1'b0, r1_mnt_l, 3'b000} - {1'b0, w2_al};
    end else begin
      w2_sum = {1'b0, r1_mnt_l, 3'b000} + {1'b0, w2_al};
    end
  end

  logic [TAG_W-1:0]        r2_tag;
  logic                    r2_spec, r2_sign;
  logic [I_DATA-1:0]       r2_spec_data;
  logic [3:0]              r2_spec_flags;
  logic signed [c_EW-1:0]  r2_exp;
  logic [c_SW:0]           r2_sum;

  // Stage 2 register: raw sum with the larger operand's exponent
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v2          <= 1'b0;
      r2_tag        <= '0;
      r2_spec       <= 1'b0;
      r2_spec_data  <= '0;
      r2_spec_flags <= '0;
      r2_sign       <= 1'b0;
      r2_exp        <= '0;
      r2_sum        <= '0;
    end else if (w_en2) begin
      r_v2          <= r_v1;
      r2_tag        <= r1_tag;
      r2_spec       <= r1_spec;
      r2_spec_data  <= r1_spec_data;
      r2_spec_flags <= r1_spec_flags;
      r2_sign       <= r1_sign;
      r2_exp        <= {2'b00, r1_exp};
      r2_sum        <= w2_sum;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [c_LZW-1:0]        w3_lz;
  logic [c_SW-1:0]         w3_nm;
  logic signed [c_EW-1:0]  w3_exp_n, w3_exp_f;
  logic                    w3_inx, w3_up;
  logic [I_MNT+1:0]        w3_rnd;
  logic [I_DATA-1:0]       w3_data;
  logic [3:0]              w3_flags;
  logic                    w_unused;

  assign w_unused = w3_rnd[I_MNT];

  // Normalise, round to nearest even and apply range / special overrides
  always_comb begin
    w3_lz = '0;
    for (int i = 0; i < c_SW; i++) begin
      if (r2_sum[i]) w3_lz = c_LZW'(c_SW - 1 - i);
    end
    if (r2_sum[c_SW]) begin
      w3_nm    = {r2_sum[c_SW:2], r2_sum[1] | r2_sum[0]};
      w3_exp_n = r2_exp + c_EW'(1);
    end else begin
      w3_nm    = r2_sum[c_SW-1:0] << w3_lz;
      w3_exp_n = r2_exp - {{(c_EW-c_LZW){1'b0}}, w3_lz};
    end
    w3_inx   = w3_nm[2] | w3_nm[1] | w3_nm[0];
    w3_up    = w3_nm[2] & (w3_nm[1] | w3_nm[0] | w3_nm[3]);
    w3_rnd   = {1'b0, w3_nm[c_SW-1:3]} + {{(I_MNT+1){1'b0}}, w3_up};
    w3_exp_f = w3_exp_n + {{(c_EW-1){1'b0}}, w3_rnd[I_MNT+1]};
    w3_data  = {r2_sign, w3_exp_f[I_EXP-1:0], w3_rnd[I_MNT-1:0]};
    w3_flags = {3'b000, w3_inx};
    if (r2_spec) begin
      w3_data  = r2_spec_data;
      w3_flags = r2_spec_flags;
    end else if (r2_sum == '0) begin
      w3_data  = '0;
      w3_flags = '0;
    end else if (w3_exp_f >= c_EXP_INF) begin
      w3_data  = {r2_sign, c_EXP_ONES, {I_MNT{1'b0}}};
      w3_flags = 4'b0101;
    end else if (w3_exp_f[c_EW-1] || (w3_exp_f == '0)) begin
      w3_data  = {r2_sign, {(I_DATA-1){1'b0}}};
      w3_flags = 4'b0011;
    end
  end

  logic [I_DATA-1:0] r3_data;
  logic [TAG_W-1:0]  r3_tag;
  logic [3:0]        r3_flags;

  // Output register: held stable while the consumer stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v3     <= 1'b0;
      r3_data  <= '0;
      r3_tag   <= '0;
      r3_flags <= '0;
    end else if (w_en3) begin
      r_v3     <= r_v2;
      r3_data  <= w3_data;
      r3_tag   <= r2_tag;
      r3_flags <= w3_flags;
    end
  end

  assign odata     = r3_data;
  assign out_tag   = r3_tag;
  assign out_flags = r3_flags;

endmodule
`default_nettype wire
